mm_sequencer: RTL and testbench
===============================

// Module: mm_sequencer
// PURPOSE
//  Initiator side of the matrix-multiply control interface. Issues the inst codes
//  0..4 that the address-control block decodes, and consumes the returned dmem
//  address. Fetches the dimension word, loads 8-word A/B blocks, MACs them into 8
//  lane accumulators, and stores C blocks. Sits between cpu_mm start logic and dmem.
// PARAMETERS
//  LANES     8   words per memory beat (fixed; the address map steps 32 bytes)
//  WORD_W    32  lane width in bits
//  INST_NOP  7   idle inst code, driven between issues
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high
//  start          in   1    one-cycle pulse, begin a multiply
//  busy           out  1    high from accepted start until done
//  done           out  1    one-cycle pulse at end of a successful run
//  error          out  1    sticky until next start: invalid dimensions
//  inst           out  3    code to control block: 0 dim, 1 A, 2 B, 3 C, 4 mm_en
//  addr_in        in   32   combinational dmem address from control block
//  mm_complete_in in   1    completion flag from control block
//  dim_we         out  1    dimension write strobe to control block
//  dim_out        out  256  dimension beat; only [31:0] is used downstream
//  mem_rd         out  1    dmem read request, held until mem_ack
//  mem_wr         out  1    dmem write request, held until mem_ack
//  mem_addr       out  32   request address, stable while request is held
//  mem_wdata      out  256  C block; lane L is at [32L+31:32L]
//  mem_rdata      in   256  read beat, valid in the mem_ack cycle
//  mem_ack        in   1    one-cycle completion, any latency >= 1 cycle
// BEHAVIOUR
//  Reset (mid-run included): state IDLE; inst=INST_NOP. busy, done, error, dim_we,
//   mem_rd and mem_wr are 0. mem_addr, mem_wdata, dim_out, all accumulators and all
//   counters are 0. An outstanding mem_ack arriving after reset is ignored.
//  Issue rule: inst holds a code 0..4 for exactly one cycle, then returns to
//   INST_NOP. Back-to-back identical codes are always separated by a NOP cycle.
//   mem_addr captures addr_in at the end of the issue cycle.
//  Dimensions: m = dim[10:0], n = dim[21:11], o = dim[31:22].
//   Valid only if m, n, o are nonzero and n%8 == 0 and o%8 == 0.
//  FSM states and transitions:
//   IDLE   -> DIM_I on start. A start while busy is ignored.
//   DIM_I  inst=0 -> DIM_R.
//   DIM_R  mem_rd until ack -> DIM_W.
//   DIM_W  dim_we=1 for one cycle, dim_out=rdata.
//          If the dimensions are invalid: error=1 -> IDLE, with no further issues and
//          no done. Otherwise -> EN.
//   EN     inst=4 -> A_I. Row counter i=0, column-block counter jb=0, k=0, acc=0.
//   A_I    inst=1 -> A_R.
//   A_R    read; latch A beat -> B_I. kk=0.
//   B_I    inst=2 -> B_R.
//   B_R    read -> MAC.
//   MAC    acc[L] += A[kk] * B[L] for L = 0..7. Each product is truncated to 32 bits,
//          and the sum wraps mod 2^32.
//          Then kk++, k++. If kk wrapped (k%8 == 0) and k < n -> A_I.
//          Else if k < n -> B_I. Else -> C_I.
//   C_I    inst=3 -> C_W.
//   C_W    mem_wr with wdata=acc until ack; then acc=0, k=0, jb++.
//          If jb == o/8: jb=0 and i++. If i == m -> FIN, else -> A_I.
//   FIN    done=1 for one cycle, busy=0 -> IDLE.
//          Internal counters decide completion. mm_complete_in is not required to be
//          high at FIN.
//  Transaction counts per run:
//   1 dim read, 1 inst=4.
//   A reads: m*(o/8)*(n/8). B reads: m*(o/8)*n. C writes: m*o/8.
//  Never assert mem_rd and mem_wr together. At most one request is outstanding.
// TESTING
//  T1: dim m=1,n=8,o=8; A row 1..8; B = identity -> single C write 1..8 at C addr; done 1 cycle.
//  T2: m=2,n=16,o=8 random data, ack latency 1 and 5 -> C matches model; 2+16... counts exactly 4 A, 32 B, 2 C.
//  T3: dim n=4 -> error=1 after dim read; no inst 1/2/3/4 issued; busy drops; no done.
//  T4: A=0xFFFFFFFF lanes, B=2 -> each C lane 0xFFFFFFF0 (n=8, wrap mod 2^32).
//  T5: reset asserted during B_R with ack pending -> next cycle all outputs at reset values; new start runs clean.
//  T6: start pulsed while busy and identical codes back-to-back -> ignored; NOP seen between every issue.

Source files
------------

// File: rtl/mm_sequencer.sv
// mm_sequencer: initiator side of the matrix-multiply control interface.
// Fetches the dimension word, streams 8-word A/B beats through eight lane
// accumulators and writes back C blocks, issuing inst codes to the
// address-control block and consuming the dmem address it returns.

// One MAC lane: acc += a * b, product truncated and sum wrapping at WORD_W.
module mm_lane #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              mac_en,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] acc
);
  // accumulator register, cleared at block start and after each C store
  always_ff @(posedge clk) begin
    if (reset || clr) acc <= '0;
    else if (mac_en)  acc <= acc + a * b;
  end
endmodule

module mm_sequencer #(
  parameter int         LANES    = 8,
  parameter int         WORD_W   = 32,
  parameter logic [2:0] INST_NOP = 3'd7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              inst,
  input  logic [31:0]             addr_in,
  input  logic                    mm_complete_in,
  output logic                    dim_we,
  output logic [LANES*WORD_W-1:0] dim_out,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [31:0]             mem_addr,
  output logic [LANES*WORD_W-1:0] mem_wdata,
  input  logic [LANES*WORD_W-1:0] mem_rdata,
  input  logic                    mem_ack
);
  localparam int KW = $clog2(LANES);

  typedef enum logic [3:0] {
    S_IDLE, S_DIM_I, S_DIM_R, S_DIM_W, S_EN, S_EN_GAP, S_A_I, S_A_R,
    S_B_I, S_B_R, S_MAC, S_C_I, S_C_W, S_FIN
  } state_t;

  state_t state, state_n;

  logic [LANES-1:0][WORD_W-1:0] a_q, b_q, acc;
  logic [10:0]   i_cnt, k_cnt;
  logic [6:0]    jb_cnt;
  logic [KW-1:0] kk;

  // Completion is decided by the internal counters; the control block's flag
  // is accepted for interface compatibility only.
  logic unused_complete;
  assign unused_complete = mm_complete_in;

  // dimension fields decoded from the latched dim beat
  logic [10:0] m_dim, n_dim;
  logic [9:0]  o_dim;
  logic        dim_ok;
  assign m_dim  = dim_out[10:0];
  assign n_dim  = dim_out[21:11];
  assign o_dim  = dim_out[31:22];
  assign dim_ok = (m_dim != '0) && (n_dim != '0) && (o_dim != '0) &&
                  (n_dim[2:0] == '0) && (o_dim[2:0] == '0);

  // loop-end tests, widened by a bit so the increment never wraps
  logic [11:0] k_nxt, i_nxt;
  logic [7:0]  jb_nxt;
  logic        k_more, jb_last, i_last;
  assign k_nxt   = {1'b0, k_cnt} + 12'd1;
  assign i_nxt   = {1'b0, i_cnt} + 12'd1;
  assign jb_nxt  = {1'b0, jb_cnt} + 8'd1;
  assign k_more  = k_nxt < {1'b0, n_dim};
  assign jb_last = jb_nxt == {1'b0, o_dim[9:3]};
  assign i_last  = i_nxt == {1'b0, m_dim};

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // next state and per-state strobes; every issue state is followed by a
  // non-issue state so inst always drops back to NOP between codes
  always_comb begin
    state_n = state;
    inst    = INST_NOP;
    busy    = 1'b1;
    done    = 1'b0;
    dim_we  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state)
      S_IDLE:   begin busy = 1'b0; if (start) state_n = S_DIM_I; end
      S_DIM_I:  begin inst = 3'd0; state_n = S_DIM_R; end
      S_DIM_R:  begin mem_rd = 1'b1; if (mem_ack) state_n = S_DIM_W; end
      S_DIM_W:  begin dim_we = 1'b1; state_n = dim_ok ? S_EN : S_IDLE; end
      S_EN:     begin inst = 3'd4; state_n = S_EN_GAP; end
      S_EN_GAP: state_n = S_A_I;
      S_A_I:    begin inst = 3'd1; state_n = S_A_R; end
      S_A_R:    begin mem_rd = 1'b1; if (mem_ack) state_n = S_B_I; end
      S_B_I:    begin inst = 3'd2; state_n = S_B_R; end
      S_B_R:    begin mem_rd = 1'b1; if (mem_ack) state_n = S_MAC; end
      S_MAC: begin
        if (!k_more)                    state_n = S_C_I;
        else if (kk == KW'(LANES - 1))  state_n = S_A_I;
        else                            state_n = S_B_I;
      end
      S_C_I:    begin inst = 3'd3; state_n = S_C_W; end
      S_C_W: begin
        mem_wr = 1'b1;
        if (mem_ack) state_n = (jb_last && i_last) ? S_FIN : S_A_I;
      end
      S_FIN:    begin busy = 1'b0; done = 1'b1; state_n = S_IDLE; end
      default:  begin busy = 1'b0; state_n = S_IDLE; end
    endcase
  end

  // datapath: address capture, beat latches, loop counters, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      dim_out  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      error    <= 1'b0;
      i_cnt    <= '0;
      k_cnt    <= '0;
      jb_cnt   <= '0;
      kk       <= '0;
    end else begin
      if (inst != INST_NOP) mem_addr <= addr_in;
      case (state)
        S_IDLE:  if (start) error <= 1'b0;
        S_DIM_R: if (mem_ack) dim_out <= mem_rdata;
        S_DIM_W: if (!dim_ok) error <= 1'b1;
        S_EN: begin
          i_cnt  <= '0;
          jb_cnt <= '0;
          k_cnt  <= '0;
        end
        S_A_R: begin
          kk <= '0;
          if (mem_ack) a_q <= mem_rdata;
        end
        S_B_R:   if (mem_ack) b_q <= mem_rdata;
        S_MAC: begin
          kk    <= kk + KW'(1);
          k_cnt <= k_nxt[10:0];
        end
        S_C_W: if (mem_ack) begin
          k_cnt <= '0;
          if (jb_last) begin
            jb_cnt <= '0;
            i_cnt  <= i_nxt[10:0];
          end else begin
            jb_cnt <= jb_nxt[6:0];
          end
        end
        default: ;
      endcase
    end
  end

  // lane array: all lanes share the broadcast A word, each takes its own B word
  logic acc_clr, mac_en;
  assign acc_clr = (state == S_EN) || ((state == S_C_W) && mem_ack);
  assign mac_en  = (state == S_MAC);

  for (genvar L = 0; L < LANES; L++) begin : g_lane
    mm_lane #(.WORD_W(WORD_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .mac_en (mac_en),
      .a      (a_q[kk]),
      .b      (b_q[L]),
      .acc    (acc[L])
    );
  end

  assign mem_wdata = acc;
endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer: models the address-control block and a
// variable-latency dmem, and checks C results, transaction counts and the
// issue/handshake rules.
module tb_mm_sequencer;
  logic         clk = 1'b0;
  logic         reset, start, busy, done, error, dim_we, mem_rd, mem_wr, mem_ack;
  logic         mm_complete_in;
  logic [2:0]   inst;
  logic [31:0]  addr_in, mem_addr;
  logic [255:0] dim_out, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .inst(inst), .addr_in(addr_in), .mm_complete_in(mm_complete_in),
    .dim_we(dim_we), .dim_out(dim_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int cmp = 0, mis = 0;
  int m_d = 1, n_d = 8, o_d = 8, lat = 1;
  logic [31:0] A_m [0:3][0:15];
  logic [31:0] B_m [0:15][0:15];
  logic [31:0] C_got [0:3][0:15];

  // address-control model: class in [31:28], per-class beat index * 32 below
  int n0, na, nb, nc, ne;
  always @(posedge clk) begin
    if (reset) begin n0 <= 0; na <= 0; nb <= 0; nc <= 0; ne <= 0; end
    else case (inst)
      3'd0: n0 <= n0 + 1;
      3'd1: na <= na + 1;
      3'd2: nb <= nb + 1;
      3'd3: nc <= nc + 1;
      3'd4: ne <= ne + 1;
      default: ;
    endcase
  end
  always_comb begin
    case (inst)
      3'd0:    addr_in = 32'h0000_0000;
      3'd1:    addr_in = 32'h1000_0000 + na * 32;
      3'd2:    addr_in = 32'h2000_0000 + nb * 32;
      3'd3:    addr_in = 32'h3000_0000 + nc * 32;
      default: addr_in = 32'h4000_0000;
    endcase
  end

  // protocol monitor
  int done_cnt, dwe_cnt, nop_viol = 0, rw_viol = 0;
  logic [2:0] prev_inst = 3'd7;
  always @(negedge clk) begin
    if (reset) begin done_cnt = 0; dwe_cnt = 0; prev_inst = 3'd7; end
    else begin
      if (done) done_cnt++;
      if (dim_we) dwe_cnt++;
      if (inst != 3'd7 && prev_inst != 3'd7) nop_viol++;
      prev_inst = inst;
    end
    if (mem_rd && mem_wr) rw_viol++;
  end

  function automatic logic [255:0] beat_for(logic [31:0] a);
    logic [255:0] r;
    int idx, ob, nb8, i, jb, kb, k;
    r = '1; idx = int'(a[27:0] >> 5); ob = o_d / 8; nb8 = n_d / 8;
    if (a[31:28] == 4'h0) begin
      r = '0; r[31:0] = {o_d[9:0], n_d[10:0], m_d[10:0]};
    end else if (ob > 0 && nb8 > 0 && a[31:28] == 4'h1) begin
      kb = idx % nb8; jb = (idx / nb8) % ob; i = idx / (nb8 * ob);
      for (int L = 0; L < 8; L++) r[32*L +: 32] = A_m[i][kb*8+L];
    end else if (ob > 0 && nb8 > 0 && a[31:28] == 4'h2) begin
      k = idx % n_d; jb = (idx / n_d) % ob;
      for (int L = 0; L < 8; L++) r[32*L +: 32] = B_m[k][jb*8+L];
    end
    return r;
  endfunction

  // dmem model: ack lat cycles after a request is first seen
  int nwr;
  initial begin
    int cnt, idx, ob;
    logic rq_wr;
    logic [31:0] rq_addr;
    logic [255:0] rq_data;
    mem_ack = 1'b0; mem_rdata = '0; cnt = -1; rq_wr = 1'b0; rq_addr = '0; rq_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cnt < 0) begin
        if (!reset && (mem_rd || mem_wr)) begin
          cnt = lat; rq_wr = mem_wr; rq_addr = mem_addr; rq_data = mem_wdata;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1; cnt = -1;
          if (!rq_wr) mem_rdata = beat_for(rq_addr);
          else begin
            nwr++;
            ob = (o_d / 8 > 0) ? o_d / 8 : 1;
            idx = int'(rq_addr[27:0] >> 5);
            if (rq_addr[31:28] == 4'h3 && idx / ob < 4)
              for (int L = 0; L < 8; L++) C_got[idx/ob][(idx%ob)*8+L] = rq_data[32*L +: 32];
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; nwr = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) C_got[i][j] = 32'hBAD0BAD0;
  endtask

  task automatic run_mm(input int mm, input int nn, input int oo, input int l,
                        input bit pulse_starts, output bit fin);
    m_d = mm; n_d = nn; o_d = oo; lat = l; fin = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (done) begin fin = 1'b1; break; end
      if (error && !busy) break;
      @(negedge clk);
      start = pulse_starts && (c % 20 == 3);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if ({inst, busy, done, error, dim_we, mem_rd, mem_wr} !== {3'd7, 6'b0}) begin
      mis++; $display("FAIL reset_ctrl: got %b want %b", {inst, busy, done, error, dim_we, mem_rd, mem_wr}, {3'd7, 6'b0}); end
    cmp++; if (mem_addr !== 32'h0) begin mis++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    cmp++; if (mem_wdata !== '0) begin mis++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    cmp++; if (dim_out !== '0) begin mis++; $display("FAIL reset_dim: got %h want 0", dim_out); end
  endtask

  task automatic test_identity();
    bit fin;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      A_m[0][k] = 32'(k + 1);
      for (int j = 0; j < 8; j++) B_m[k][j] = (k == j) ? 32'd1 : 32'd0;
    end
    run_mm(1, 8, 8, 1, 1'b0, fin);
    cmp++; if (fin !== 1'b1) begin mis++; $display("FAIL t1_done: got %0d want 1", fin); end
    cmp++; if (done_cnt !== 1) begin mis++; $display("FAIL t1_done_width: got %0d want 1", done_cnt); end
    cmp++; if (nwr !== 1) begin mis++; $display("FAIL t1_c_writes: got %0d want 1", nwr); end
    for (int L = 0; L < 8; L++) begin
      cmp++; if (C_got[0][L] !== 32'(L + 1)) begin
        mis++; $display("FAIL t1_c_lane%0d: got %h want %h", L, C_got[0][L], 32'(L + 1)); end
    end
  endtask

  task automatic test_random_latency(input int l);
    bit fin;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) A_m[i][k] = $urandom;
    for (int k = 0; k < 16; k++) for (int j = 0; j < 16; j++) B_m[k][j] = $urandom;
    run_mm(2, 16, 8, l, 1'b0, fin);
    cmp++; if (fin !== 1'b1) begin mis++; $display("FAIL t2_done lat%0d: got %0d want 1", l, fin); end
    cmp++; if (n0 !== 1 || ne !== 1) begin mis++; $display("FAIL t2_dim_en lat%0d: got %0d/%0d want 1/1", l, n0, ne); end
    cmp++; if (na !== 4) begin mis++; $display("FAIL t2_a_count lat%0d: got %0d want 4", l, na); end
    cmp++; if (nb !== 32) begin mis++; $display("FAIL t2_b_count lat%0d: got %0d want 32", l, nb); end
    cmp++; if (nc !== 2 || nwr !== 2) begin mis++; $display("FAIL t2_c_count lat%0d: got %0d/%0d want 2", l, nc, nwr); end
    for (int i = 0; i < 2; i++) for (int j = 0; j < 8; j++) begin
      e = '0;
      for (int k = 0; k < 16; k++) e = e + A_m[i][k] * B_m[k][j];
      cmp++; if (C_got[i][j] !== e) begin
        mis++; $display("FAIL t2_c[%0d][%0d] lat%0d: got %h want %h", i, j, l, C_got[i][j], e); end
    end
  endtask

  task automatic test_bad_dims();
    bit fin;
    int bad [3][3] = '{'{1, 4, 8}, '{0, 8, 8}, '{1, 8, 12}};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      run_mm(bad[t][0], bad[t][1], bad[t][2], 2, 1'b0, fin);
      cmp++; if (error !== 1'b1 || busy !== 1'b0) begin
        mis++; $display("FAIL t3_error case%0d: got err=%b busy=%b want 1/0", t, error, busy); end
      cmp++; if (fin !== 1'b0 || done_cnt !== 0) begin
        mis++; $display("FAIL t3_no_done case%0d: got %0d want 0", t, done_cnt); end
      cmp++; if (na + nb + nc + ne !== 0 || n0 !== 1 || dwe_cnt !== 1) begin
        mis++; $display("FAIL t3_issues case%0d: got a%0d b%0d c%0d en%0d dim%0d we%0d want 0 0 0 0 1 1",
                        t, na, nb, nc, ne, n0, dwe_cnt); end
    end
    repeat (5) @(negedge clk);
    cmp++; if (error !== 1'b1) begin mis++; $display("FAIL t3_sticky: got %b want 1", error); end
    run_mm(1, 8, 8, 1, 1'b0, fin);
    cmp++; if (error !== 1'b0 || fin !== 1'b1) begin
      mis++; $display("FAIL t3_clear: got err=%b fin=%b want 0/1", error, fin); end
  endtask

  task automatic test_wrap();
    bit fin;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      A_m[0][k] = 32'hFFFF_FFFF;
      for (int j = 0; j < 8; j++) B_m[k][j] = 32'd2;
    end
    run_mm(1, 8, 8, 3, 1'b0, fin);
    cmp++; if (fin !== 1'b1) begin mis++; $display("FAIL t4_done: got %0d want 1", fin); end
    for (int L = 0; L < 8; L++) begin
      cmp++; if (C_got[0][L] !== 32'hFFFF_FFF0) begin
        mis++; $display("FAIL t4_c_lane%0d: got %h want fffffff0", L, C_got[0][L]); end
    end
  endtask

  task automatic test_reset_midrun();
    bit fin, seen;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      A_m[0][k] = 32'(k + 1);
      for (int j = 0; j < 8; j++) B_m[k][j] = (k == j) ? 32'd1 : 32'd0;
    end
    m_d = 1; n_d = 8; o_d = 8; lat = 5; seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (mem_rd && mem_addr[31:28] == 4'h2) seen = 1'b1;
    end
    cmp++; if (seen !== 1'b1) begin mis++; $display("FAIL t5_reach_b_read: got %b want 1", seen); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    cmp++; if ({inst, busy, done, error, dim_we, mem_rd, mem_wr} !== {3'd7, 6'b0}) begin
      mis++; $display("FAIL t5_reset_ctrl: got %b want %b", {inst, busy, done, error, dim_we, mem_rd, mem_wr}, {3'd7, 6'b0}); end
    cmp++; if (mem_addr !== 32'h0 || mem_wdata !== '0 || dim_out !== '0) begin
      mis++; $display("FAIL t5_reset_data: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0 || inst !== 3'd7) begin
      mis++; $display("FAIL t5_stale_ack: got busy=%b rd=%b inst=%0d want 0 0 7", busy, mem_rd, inst); end
    nwr = 0;
    for (int j = 0; j < 8; j++) C_got[0][j] = 32'hBAD0BAD0;
    run_mm(1, 8, 8, 2, 1'b0, fin);
    cmp++; if (fin !== 1'b1 || na !== 1 || nb !== 8 || nc !== 1) begin
      mis++; $display("FAIL t5_rerun: got fin%0d a%0d b%0d c%0d want 1 1 8 1", fin, na, nb, nc); end
    for (int L = 0; L < 8; L++) begin
      cmp++; if (C_got[0][L] !== 32'(L + 1)) begin
        mis++; $display("FAIL t5_c_lane%0d: got %h want %h", L, C_got[0][L], 32'(L + 1)); end
    end
  endtask

  task automatic test_busy_start();
    bit fin;
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      A_m[0][k] = 32'(3 * k + 1);
      for (int j = 0; j < 16; j++) B_m[k][j] = 32'(k + 2 * j);
    end
    run_mm(1, 16, 16, 1, 1'b1, fin);
    cmp++; if (fin !== 1'b1 || done_cnt !== 1 || n0 !== 1) begin
      mis++; $display("FAIL t6_single_run: got fin%0d done%0d dim%0d want 1 1 1", fin, done_cnt, n0); end
    cmp++; if (na !== 4 || nb !== 32 || nc !== 2) begin
      mis++; $display("FAIL t6_counts: got a%0d b%0d c%0d want 4 32 2", na, nb, nc); end
    for (int j = 0; j < 16; j++) begin
      e = '0;
      for (int k = 0; k < 16; k++) e = e + A_m[0][k] * B_m[k][j];
      cmp++; if (C_got[0][j] !== e) begin
        mis++; $display("FAIL t6_c[0][%0d]: got %h want %h", j, C_got[0][j], e); end
    end
    cmp++; if (nop_viol !== 0) begin mis++; $display("FAIL nop_between_issues: got %0d want 0", nop_viol); end
    cmp++; if (rw_viol !== 0) begin mis++; $display("FAIL rd_wr_overlap: got %0d want 0", rw_viol); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mm_complete_in = 1'b0; nwr = 0;
    test_reset();
    test_identity();
    test_random_latency(1);
    test_random_latency(5);
    test_bad_dims();
    test_wrap();
    test_reset_midrun();
    test_busy_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
